hpi_io_bridge: RTL and testbench



---
 rtl/hpi_pkg.sv | 32 +++
 rtl/hpi_tristate_pad.sv | 42 ++++
 rtl/hpi_io_bridge.sv | 169 ++++++++++++++++
 tb/tb_hpi_io_bridge.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
// Shared definitions for the CY7C67200 HPI bridge.
//   state_t    : access sequencer states
//   DATA..STATUS : HPI register select values presented on OTG_ADDR
//   HPI_W      : HPI data bus width
package hpi_pkg;

    localparam int HPI_W = 16;

    localparam logic [1:0] DATA    = 2'd0;
    localparam logic [1:0] MAILBOX = 2'd1;
    localparam logic [1:0] ADDRESS = 2'd2;
    localparam logic [1:0] STATUS  = 2'd3;

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/hpi_tristate_pad.sv
// Physical HPI data bus pad.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : latch load_data as the write data to present on the bus
//   oe_next    : drive enable for the next cycle (registered here)
//   capture    : sample the bus into rdata on this edge
//   rdata      : captured read data, held until the next capture
//   pad        : bidirectional HPI data bus
module hpi_tristate_pad
    import hpi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [HPI_W-1:0] load_data,
    input  logic             oe_next,
    input  logic             capture,
    output logic [HPI_W-1:0] rdata,
    inout  wire  [HPI_W-1:0] pad
);

    logic             oe_reg;
    logic [HPI_W-1:0] dout_reg;
    logic [HPI_W-1:0] rdata_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_reg    <= 1'b0;
            dout_reg  <= '0;
            rdata_reg <= '0;
        end else begin
            oe_reg <= oe_next;
            if (load)
                dout_reg <= load_data;
            if (capture)
                rdata_reg <= pad;
        end
    end

    assign pad   = oe_reg ? dout_reg : {HPI_W{1'bz}};
    assign rdata = rdata_reg;

endmodule

// File: rtl/hpi_io_bridge.sv
// Turns the slow software-driven HPI PIO requests into one correctly timed
// CY7C67200 host port access, and owns the OTG chip reset.
//   clk_clk, reset_reset_n          : clock, asynchronous active-low reset
//   sw_address/cs_n/r_n/w_n/wdata   : request from the SoC PIOs
//   sw_rdata                        : last captured read data
//   busy                            : access accepted and not yet released
//   proto_err                       : sticky, read and write requested together
//   OTG_ADDR/CS_N/RD_N/WR_N/RST_N   : HPI control pins (all registered)
//   OTG_DATA                        : HPI data bus
module hpi_io_bridge
    import hpi_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1,
    parameter int RST_CYCLES    = 50000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [1:0]       sw_address,
    input  logic             sw_cs_n,
    input  logic             sw_r_n,
    input  logic             sw_w_n,
    input  logic [HPI_W-1:0] sw_wdata,
    output logic [HPI_W-1:0] sw_rdata,
    output logic             busy,
    output logic             proto_err,
    output logic [1:0]       OTG_ADDR,
    output logic             OTG_CS_N,
    output logic             OTG_RD_N,
    output logic             OTG_WR_N,
    output logic             OTG_RST_N,
    inout  wire  [HPI_W-1:0] OTG_DATA
);

    localparam int MAX_CYC = max4(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, RST_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    // Counters count down to zero, so each phase loads its length minus one.
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);

    if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1 || RST_CYCLES < 1) begin : g_param_check
        $error("hpi_io_bridge: all cycle parameters must be >= 1");
    end

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dir_wr_reg, dir_wr_next;
    logic [1:0]       addr_reg;
    logic             cs_n_reg, rd_n_reg, wr_n_reg, otg_rst_n_reg;
    logic             busy_reg, proto_err_reg, proto_err_next;
    logic             accept, capture, in_access, oe_next;
    logic             rd_req, wr_req, bad, released;

    assign rd_req   = !sw_cs_n && !sw_r_n &&  sw_w_n;
    assign wr_req   = !sw_cs_n && !sw_w_n &&  sw_r_n;
    assign bad      = !sw_cs_n && !sw_r_n && !sw_w_n;
    assign released =  sw_cs_n || (sw_r_n && sw_w_n);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        dir_wr_next    = dir_wr_reg;
        proto_err_next = proto_err_reg;
        accept         = 1'b0;
        capture        = 1'b0;
        unique case (state_reg)
            RST_HOLD: begin
                if (cnt_reg == '0) state_next = IDLE;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            IDLE: begin
                if (rd_req || wr_req) begin
                    accept      = 1'b1;
                    dir_wr_next = wr_req;
                    state_next  = SETUP;
                    cnt_next    = SETUP_LOAD;
                end else if (bad) begin
                    proto_err_next = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = STROBE;
                    cnt_next   = STROBE_LOAD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            STROBE: begin
                if (cnt_reg == '0) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
                    // Sample at the end of the last low cycle, while RD_N is still low.
                    capture    = !dir_wr_reg;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_reg == '0) state_next = DONE;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            DONE: begin
                // Wait for software to drop the request so one request is one access.
                if (released) state_next = IDLE;
            end
            default: begin
                state_next = RST_HOLD;
                cnt_next   = RST_LOAD;
            end
        endcase
    end

    // Pin registers are loaded from the next state so that pins line up
    // with the state they belong to.
    assign in_access = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);
    assign oe_next   = in_access && dir_wr_next;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg     <= RST_HOLD;
            cnt_reg       <= RST_LOAD;
            dir_wr_reg    <= 1'b0;
            addr_reg      <= 2'd0;
            cs_n_reg      <= 1'b1;
            rd_n_reg      <= 1'b1;
            wr_n_reg      <= 1'b1;
            otg_rst_n_reg <= 1'b0;
            busy_reg      <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            dir_wr_reg    <= dir_wr_next;
            proto_err_reg <= proto_err_next;
            if (accept)
                addr_reg <= sw_address;
            cs_n_reg      <= !in_access;
            rd_n_reg      <= !((state_next == STROBE) && !dir_wr_next);
            wr_n_reg      <= !((state_next == STROBE) &&  dir_wr_next);
            otg_rst_n_reg <= (state_next != RST_HOLD);
            busy_reg      <= (state_next != IDLE);
        end
    end

    hpi_tristate_pad u_pad (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .load      (accept),
        .load_data (sw_wdata),
        .oe_next   (oe_next),
        .capture   (capture),
        .rdata     (sw_rdata),
        .pad       (OTG_DATA)
    );

    assign busy      = busy_reg;
    assign proto_err = proto_err_reg;
    assign OTG_ADDR  = addr_reg;
    assign OTG_CS_N  = cs_n_reg;
    assign OTG_RD_N  = rd_n_reg;
    assign OTG_WR_N  = wr_n_reg;
    assign OTG_RST_N = otg_rst_n_reg;

endmodule

// File: tb/tb_hpi_io_bridge.sv
module tb_hpi_io_bridge;
    import hpi_pkg::*;

    // The bus is pulled up, so an undriven bus reads as all ones.
    localparam logic [15:0] BUS_IDLE = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sw_address;
    logic        sw_cs_n, sw_r_n, sw_w_n;
    logic [15:0] sw_wdata;
    logic [15:0] sw_rdata;
    logic        busy, proto_err;
    logic [1:0]  otg_addr;
    logic        otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n;
    wire  [15:0] otg_data;
    logic [15:0] model_rdata;

    pullup pu_bus (otg_data);
    // OTG chip model: drives read data while RD_N is low.
    assign otg_data = otg_rd_n ? 16'hzzzz : model_rdata;

    always #5 clk = ~clk;

    hpi_io_bridge #(.RST_CYCLES(10)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .sw_address    (sw_address),
        .sw_cs_n       (sw_cs_n),
        .sw_r_n        (sw_r_n),
        .sw_w_n        (sw_w_n),
        .sw_wdata      (sw_wdata),
        .sw_rdata      (sw_rdata),
        .busy          (busy),
        .proto_err     (proto_err),
        .OTG_ADDR      (otg_addr),
        .OTG_CS_N      (otg_cs_n),
        .OTG_RD_N      (otg_rd_n),
        .OTG_WR_N      (otg_wr_n),
        .OTG_RST_N     (otg_rst_n),
        .OTG_DATA      (otg_data)
    );

    typedef struct {
        logic [1:0]  addr;
        bit          wr;
        logic [15:0] data;
        int          cs_len;
        int          stb_len;
        int          stb_start;
        int          pulses;
        logic [15:0] rdata;
    } acc_t;

    acc_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_done = 0;
    int   start_done = 0;
    int   stray = 0;
    logic [15:0] exp_rdata = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          m_cs_len = 0, m_stb_len = 0, m_stb_start = 0, m_pulses = 0, m_bad = 0;
    bit          m_stb_prev = 0, m_wr_seen = 0, m_rd_seen = 0, m_rdata_taken = 0;
    logic [1:0]  m_addr;
    logic [15:0] m_rdata;
    logic [15:0] bus_log [16];
    bit          stb_log [16];
    acc_t        m_e;

    always @(negedge clk) begin
        bit          stb_now;
        logic [15:0] exp_b;
        if (otg_cs_n === 1'b0) begin
            if (m_cs_len == 0) m_addr = otg_addr;
            else if (otg_addr !== m_addr) m_bad++;
            if (otg_rst_n !== 1'b1) m_bad++;
            if (m_cs_len < 16) begin
                bus_log[m_cs_len] = otg_data;
                stb_log[m_cs_len] = !otg_rd_n;
            end
            m_cs_len++;
            stb_now = !otg_rd_n || !otg_wr_n;
            if (stb_now) begin
                if (!m_stb_prev) begin
                    m_pulses++;
                    if (m_pulses == 1) m_stb_start = m_cs_len;
                end
                m_stb_len++;
                if (!otg_wr_n) m_wr_seen = 1;
                if (!otg_rd_n) m_rd_seen = 1;
            end else if (m_stb_prev && !m_rdata_taken) begin
                m_rdata = sw_rdata;
                m_rdata_taken = 1;
            end
            m_stb_prev = stb_now;
        end else begin
            if (!otg_rd_n || !otg_wr_n) stray++;
            if (m_cs_len > 0) begin
                if (!m_rdata_taken) m_rdata = sw_rdata;
                $display("access %0d: wr=%0b rd=%0b addr=%0d cs_len=%0d stb_len=%0d stb_start=%0d pulses=%0d rdata=%h",
                         acc_done, m_wr_seen, m_rd_seen, m_addr, m_cs_len, m_stb_len, m_stb_start, m_pulses, m_rdata);
                if (exp_q.size() == 0) begin
                    chk("unexpected_access", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    for (int i = 0; i < m_cs_len && i < 16; i++) begin
                        if (m_e.wr)          exp_b = m_e.data;
                        else if (stb_log[i]) exp_b = m_e.data;
                        else                 exp_b = BUS_IDLE;
                        if (bus_log[i] !== exp_b) m_bad++;
                    end
                    if (otg_data !== BUS_IDLE) m_bad++;
                    chk("acc_addr",      m_addr, m_e.addr);
                    chk("acc_dir",       {m_wr_seen, m_rd_seen}, {m_e.wr, !m_e.wr});
                    chk("acc_cs_len",    m_cs_len, m_e.cs_len);
                    chk("acc_stb_len",   m_stb_len, m_e.stb_len);
                    chk("acc_stb_start", m_stb_start, m_e.stb_start);
                    chk("acc_pulses",    m_pulses, m_e.pulses);
                    chk("acc_rdata",     m_rdata, m_e.rdata);
                    chk("acc_bus_addr_rst", m_bad, 0);
                end
                m_cs_len = 0; m_stb_len = 0; m_stb_start = 0; m_pulses = 0; m_bad = 0;
                m_stb_prev = 0; m_wr_seen = 0; m_rd_seen = 0; m_rdata_taken = 0;
                acc_done++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic release_and_count();
        int n = 0;
        tick();
        rst_n = 1'b1;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            #1;
            if (n == 1) chk("busy_in_rst_hold", busy, 1);
            if (otg_rst_n === 1'b1) break;
        end
        chk("rst_hold_len", n, 10);
        chk("busy_after_rst_hold", busy, 0);
        chk("cs_n_after_rst_hold", otg_cs_n, 1);
    endtask

    task automatic start_access(input bit wr, input logic [1:0] a, input logic [15:0] d);
        acc_t e;
        e.addr = a; e.wr = wr; e.cs_len = 6; e.stb_len = 4; e.stb_start = 2; e.pulses = 1;
        if (wr) e.data = d;
        else begin
            e.data = model_rdata;
            exp_rdata = model_rdata;
        end
        e.rdata = exp_rdata;
        exp_q.push_back(e);
        start_done = acc_done;
        sw_address = a;
        sw_wdata   = d;
        sw_cs_n    = 1'b0;
        if (wr) sw_w_n = 1'b0;
        else    sw_r_n = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (acc_done <= start_done && k < 300) begin
            tick();
            k++;
        end
        chk("access_completed", 32'(acc_done > start_done), 1);
    endtask

    task automatic finish_access(input int extra);
        // Changing address and data mid-access must not reach the pins.
        tick(); tick();
        sw_address = ~sw_address;
        sw_wdata   = ~sw_wdata;
        wait_done();
        repeat (extra) tick();
        chk("busy_held", busy, 1);
        sw_r_n = 1'b1;
        sw_w_n = 1'b1;
        tick();
        chk("busy_release", busy, 0);
        sw_cs_n = 1'b1;
        tick();
    endtask

    task automatic do_access(input bit wr, input logic [1:0] a, input logic [15:0] d, input int extra);
        tick();
        start_access(wr, a, d);
        finish_access(extra);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int k;
        rst_n = 1'b0;
        sw_cs_n = 1'b1; sw_r_n = 1'b1; sw_w_n = 1'b1;
        sw_address = 2'd0; sw_wdata = 16'h0000; model_rdata = 16'h0000;
        repeat (3) tick();

        chk("rst_cs_n", otg_cs_n, 1);
        chk("rst_rd_n", otg_rd_n, 1);
        chk("rst_wr_n", otg_wr_n, 1);
        chk("rst_otg_rst_n", otg_rst_n, 0);
        chk("rst_addr", otg_addr, 0);
        chk("rst_bus", otg_data, BUS_IDLE);
        chk("rst_rdata", sw_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_proto_err", proto_err, 0);

        release_and_count();

        do_access(1'b1, ADDRESS, 16'hBEEF, 0);

        model_rdata = 16'h1234;
        do_access(1'b0, DATA, 16'h0000, 0);
        model_rdata = 16'h5555;
        repeat (5) tick();
        chk("rdata_stable", sw_rdata, 16'h1234);

        do_access(1'b1, MAILBOX, 16'h0F0F, 0);
        chk("rdata_after_write", sw_rdata, 16'h1234);

        do_access(1'b1, STATUS, 16'hCAFE, 100);
        do_access(1'b1, STATUS, 16'h1357, 0);

        // read and write requested together
        tick();
        sw_cs_n = 1'b0; sw_r_n = 1'b0; sw_w_n = 1'b0;
        tick();
        chk("proto_err_set", proto_err, 1);
        chk("proto_busy", busy, 0);
        repeat (5) tick();
        sw_cs_n = 1'b1; sw_r_n = 1'b1; sw_w_n = 1'b1;
        repeat (3) tick();
        chk("proto_err_sticky", proto_err, 1);

        model_rdata = 16'hA5C3;
        do_access(1'b0, STATUS, 16'h0000, 0);

        // reset during the second strobe cycle of a write
        begin
            acc_t e;
            e.addr = ADDRESS; e.wr = 1'b1; e.data = 16'h6789;
            e.cs_len = 3; e.stb_len = 2; e.stb_start = 2; e.pulses = 1; e.rdata = 16'h0000;
            exp_q.push_back(e);
        end
        tick();
        start_done = acc_done;
        sw_address = ADDRESS; sw_wdata = 16'h6789; sw_cs_n = 1'b0; sw_w_n = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (otg_wr_n !== 1'b0 && k < 50);
        chk("abort_strobe_seen", otg_wr_n, 0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_wr_n", otg_wr_n, 1);
        chk("abort_cs_n", otg_cs_n, 1);
        chk("abort_bus", otg_data, BUS_IDLE);
        chk("abort_otg_rst_n", otg_rst_n, 0);
        chk("abort_rdata", sw_rdata, 0);
        exp_rdata = 16'h0000;
        sw_cs_n = 1'b1; sw_w_n = 1'b1;
        wait_done();

        // request held through RST_HOLD is served only after it completes
        tick();
        start_access(1'b1, MAILBOX, 16'h2468);
        release_and_count();
        finish_access(0);

        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);
        chk("stray_strobe", stray, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
